jk_excite_driver: RTL and testbench
===================================

# jk_excite_driver

Inverse of the JK flip-flop: converts a stream of desired register states into per-bit J/K drive using the JK excitation table, then confirms the result by reading the register back. It feeds a bank of WIDTH external JK flip-flops (clk, reset, J, K, Q, Qbar per bit) and sits between a sequence source and that bank, usually in directed benches and small sequencers.

## Interface
- WIDTH, 4: number of JK flip-flops driven.
- DEPTH, 4: input FIFO entries; must be a power of 2 and at least 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-low reset. It is sampled only on the rising edge of clk.
- in_valid  input  1  in_target is presented.
- in_ready  output  1  FIFO can accept a word; equals !full.
- in_target  input  WIDTH  desired next Q of the bank.
- J  output  WIDTH  registered J drive to the bank.
- K  output  WIDTH  registered K drive to the bank.
- q_fb  input  WIDTH  Q read back from the bank.
- busy  output  1  high whenever the FSM is not IDLE or the FIFO is not empty.
- done  output  1  one-cycle pulse at the end of each CHECK.
- err  output  1  sticky flag set on a readback mismatch.
- steps  output  8  count of completed words; wraps at 255→0.

## Operation
- A word is pushed when in_valid && in_ready. Words are applied in strict FIFO order.
- FSM states:
  - IDLE → DRIVE when the FIFO is not empty. The head is popped on this transition.
  - DRIVE → HOLD, unconditionally.
  - HOLD → CHECK, unconditionally.
  - CHECK → DRIVE if the FIFO is not empty (pop again); otherwise → IDLE.
- Excitation per bit i, with cur = q_fb[i] sampled on entry to DRIVE and tgt = target[i]:
  - 0→0: J=0, K=0.
  - 0→1: J=1, K=0.
  - 1→0: J=0, K=1.
  - 1→1: J=0, K=0.
  - Don't-care terms always resolve to 0, so J&K is never 1 and toggle mode is never used.
- J and K carry the computed values only for the single cycle the FSM is in DRIVE. In every other state J=K=0, so the bank holds.
- In CHECK:
  - Compare q_fb with the stored target. If any bit differs, set err.
  - done pulses and steps increments whether or not the check passed.
- err is cleared only by reset.
- A push and a pop in the same cycle are both honoured. The FIFO count is unchanged.
- While the FIFO is full, in_ready=0 and nothing is pushed.

## Timing
- Reset values: J=0, K=0, in_ready=1, busy=0, done=0, err=0, steps=0. FSM is in IDLE, FIFO is empty, all pointers are 0.
- A word accepted at edge n into an empty FIFO with the FSM in IDLE:
  - Pop and FSM → DRIVE at edge n+1; J/K are valid during cycle n+1.
  - The bank captures at edge n+2 (FSM → HOLD).
  - FSM → CHECK at edge n+3.
  - done is high during cycle n+3; the compare, err and steps update at edge n+4.
- Sustained throughput is one word per 3 cycles (DRIVE, HOLD, CHECK).
- in_ready is combinational from the FIFO count only. It has no dependence on in_valid.
- Reset asserted mid-operation takes effect at the next edge:
  - FIFO is flushed and the FSM returns to IDLE.
  - J=K=0 and all outputs go to their reset values.
  - A word offered in the same cycle as reset is dropped.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.

## Structure
- Package jk_pkg holds:
  - the state enum: IDLE, DRIVE, HOLD, CHECK;
  - a function jk_excite(cur, tgt) returning {J, K} for one bit;
  - a constant STEPS_W = 8.
- Sub-module sync_fifo, parameterised by WIDTH and DEPTH, with push/pop/full/empty. It uses the same clk and reset, with synchronous active-low reset.
- The top level holds the FSM, the stored target register, the J/K output registers, the compare logic, err and steps.

## Test plan
Bench instantiates WIDTH=4 JK flip-flops fed by J/K, with q_fb tied to their Q. The bank is reset to Q=0000.
- Hold reset=0 for 2 edges, then release → J=K=0000, in_ready=1, busy=0, err=0, steps=0.
- Push 1010 with Q=0000 → one DRIVE cycle with J=1010, K=0000. Then Q=1010, done pulses once, steps=1, err=0.
- Push 1010 then 0110 back-to-back → second DRIVE has J=0100, K=1000. Final Q=0110, steps=2, no cycle with J&K≠0.
- Hold in_valid with 6 distinct words while the drain is slow → in_ready drops while the FIFO holds 4 words. All 6 are applied in order, final Q equals the 6th word, steps=6.
- Force q_fb[0] stuck at 0, push 0001 → J=0001 in DRIVE. In CHECK err rises and stays 1 across later good words; done still pulses.
- Assert reset during DRIVE with 2 words queued → next edge has J=K=0, busy=0, steps=0. After release, no queued word is applied.

Source files
------------

// File: rtl/jk_excite_driver_pkg.sv
// jk_pkg: shared types and helpers for the JK excitation driver.
//   state_e   - sequencing states of the driver FSM
//   jk_excite - per-bit JK excitation ({J,K}) for a cur->tgt transition
//   STEPS_W   - width of the completed-word counter
package jk_pkg;

  localparam int unsigned STEPS_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2,
    CHECK = 2'd3
  } state_e;

  // Don't-care terms resolve to 0, so J and K are never both high.
  function automatic logic [1:0] jk_excite(input logic cur, input logic tgt);
    return {~cur & tgt, cur & ~tgt};
  endfunction

endpackage

// File: rtl/jk_excite_driver_if.sv
// jk_excite_driver_if: sequence-source and JK-bank signals of the driver.
//   in_valid/in_ready/in_target - target word handshake
//   J/K                         - drive to the JK bank
//   q_fb                        - Q read back from the bank
//   busy/done/err/steps         - status
// master: the source/bank side, slave: the driver.
interface jk_excite_driver_if
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_target;
  logic [WIDTH-1:0]   J;
  logic [WIDTH-1:0]   K;
  logic [WIDTH-1:0]   q_fb;
  logic               busy;
  logic               done;
  logic               err;
  logic [STEPS_W-1:0] steps;

  modport master (
    output in_valid, in_target, q_fb,
    input  in_ready, J, K, busy, done, err, steps
  );

  modport slave (
    input  in_valid, in_target, q_fb,
    output in_ready, J, K, busy, done, err, steps
  );

endinterface

// File: rtl/jk_excite_driver_sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous active-low reset.
//   clk, reset       - clock, synchronous active-low reset
//   push_i / pop_i   - write / read requests (ignored when full / empty)
//   wdata_i, rdata_o - write data, head of queue (valid when !empty_o)
//   full_o, empty_o  - occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Extra MSB on each pointer separates full from empty.
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointer update; reset flushes the queue and drops any same-cycle push.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Storage.
  always_ff @(posedge clk) begin
    if (reset && do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/jk_excite_driver.sv
// jk_excite_driver: turns a stream of target words into one cycle of J/K
// drive per word for an external JK bank, then checks the readback.
//   clk, reset - clock, synchronous active-low reset
//   bus        - jk_excite_driver_if slave (handshake, J/K, q_fb, status)
module jk_excite_driver
  import jk_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  jk_excite_driver_if.slave  bus
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;
  logic               err_q, err_d;
  logic [STEPS_W-1:0] steps_q, steps_d;
  logic [WIDTH-1:0]   head;
  logic               pop, full, empty;
  logic [1:0]         jk_bit;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.in_valid),
    .pop_i   (pop),
    .wdata_i (bus.in_target),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      j_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      j_q     <= j_d;
      k_q     <= k_d;
      err_q   <= err_d;
      steps_q <= steps_d;
    end
  end

  // Next state; J/K are nonzero only on the edge entering DRIVE.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tgt_d   = tgt_q;
    j_d     = '0;
    k_d     = '0;
    err_d   = err_q;
    steps_d = steps_q;
    jk_bit  = '0;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = DRIVE;
          pop     = 1'b1;
        end
      end
      DRIVE: state_d = HOLD;
      HOLD:  state_d = CHECK;
      CHECK: begin
        if (bus.q_fb != tgt_q) err_d = 1'b1;
        steps_d = steps_q + STEPS_W'(1);
        if (!empty) begin
          state_d = DRIVE;
          pop     = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Current Q is sampled as the popped word becomes the target.
    if (pop) begin
      tgt_d = head;
      for (int i = 0; i < int'(WIDTH); i++) begin
        jk_bit = jk_excite(bus.q_fb[i], head[i]);
        j_d[i] = jk_bit[1];
        k_d[i] = jk_bit[0];
      end
    end
  end

  assign bus.in_ready = ~full;
  assign bus.J        = j_q;
  assign bus.K        = k_q;
  assign bus.busy     = (state_q != IDLE) | ~empty;
  assign bus.done     = (state_q == CHECK);
  assign bus.err      = err_q;
  assign bus.steps    = steps_q;

endmodule

// File: tb/tb_jk_excite_driver.sv
// Self-checking bench: JK bank model on J/K/q_fb, transaction-level reference
// model of the driver, per-cycle compare plus directed literal checks.
module tb_jk_excite_driver;
  import jk_pkg::*;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  jk_excite_driver_if #(.WIDTH(WIDTH)) bus();

  jk_excite_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // External JK flip-flop bank; stuck_mask forces readback bits to 0.
  logic [3:0] bank_q;
  logic [3:0] stuck_mask = 4'b0000;
  always @(posedge clk) begin
    if (!reset) bank_q <= 4'b0000;
    else begin
      for (int i = 0; i < 4; i++) begin
        case ({bus.J[i], bus.K[i]})
          2'b10:   bank_q[i] <= 1'b1;
          2'b01:   bank_q[i] <= 1'b0;
          2'b11:   bank_q[i] <= ~bank_q[i];
          default: bank_q[i] <= bank_q[i];
        endcase
      end
    end
  end
  assign bus.q_fb = bank_q & ~stuck_mask;

  // Reference model: queue of pending words plus position in the 3-cycle apply window.
  logic [3:0] m_q[$];
  int         m_phase = 0;   // 0 idle, 1 drive, 2 hold, 3 check
  logic [3:0] m_tgt = 0, m_cur = 0;
  logic       m_err = 0;
  logic [7:0] m_steps = 0;
  bit         mp_push, mp_pop;

  always @(posedge clk) begin
    if (!reset) begin
      m_q.delete();
      m_phase = 0; m_tgt = 0; m_cur = 0; m_err = 0; m_steps = 0;
    end else begin
      mp_push = bus.in_valid && (m_q.size() < DEPTH);
      mp_pop  = (m_phase == 0 || m_phase == 3) && (m_q.size() != 0);
      if (m_phase == 3) begin
        if (bus.q_fb != m_tgt) m_err = 1;
        m_steps = m_steps + 8'd1;
      end
      if (mp_pop) begin
        m_cur = bus.q_fb;
        m_tgt = m_q.pop_front();
        m_phase = 1;
      end else if (m_phase == 0 || m_phase == 3) m_phase = 0;
      else m_phase = m_phase + 1;
      if (mp_push) m_q.push_back(bus.in_target);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare and logging.
  bit         chk_en = 0;
  logic [3:0] drv_j[$], drv_k[$], done_q[$];
  int         done_cnt = 0, act_cnt = 0;
  bit         saw_block = 0;
  logic [3:0] exp_j, exp_k;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_j = (m_phase == 1) ? (~m_cur & m_tgt) : 4'b0000;
      exp_k = (m_phase == 1) ? (m_cur & ~m_tgt) : 4'b0000;
      chk("J", 32'(bus.J), 32'(exp_j));
      chk("K", 32'(bus.K), 32'(exp_k));
      chk("jk_overlap", 32'(bus.J & bus.K), 32'd0);
      chk("done", 32'(bus.done), 32'(m_phase == 3));
      chk("busy", 32'(bus.busy), 32'(m_phase != 0 || m_q.size() != 0));
      chk("in_ready", 32'(bus.in_ready), 32'(m_q.size() < DEPTH));
      chk("err", 32'(bus.err), 32'(m_err));
      chk("steps", 32'(bus.steps), 32'(m_steps));
      if (m_phase == 1) begin
        drv_j.push_back(bus.J);
        drv_k.push_back(bus.K);
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_q.push_back(bus.q_fb);
      end
      if ((bus.J | bus.K) != 4'b0000) act_cnt++;
      if (m_q.size() == DEPTH && bus.in_ready === 1'b0) saw_block = 1;
    end
  end

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic push_word(input logic [3:0] w);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_target = w;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 32'(n < 200), 32'd1);
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus.busy !== 1'b0 || m_phase != 0 || m_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic clear_logs();
    drv_j.delete(); drv_k.delete(); done_q.delete();
  endtask

  logic [3:0] words[6] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100};
  logic [7:0] s0;
  int         d0, n;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_target = 4'b0000;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    chk_en = 1;
    @(negedge clk);
    // Reset state.
    chk("rst_J", 32'(bus.J), 32'd0);
    chk("rst_K", 32'(bus.K), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_steps", 32'(bus.steps), 32'd0);
    reset = 1'b1;

    // Single word from Q=0000.
    s0 = bus.steps; d0 = done_cnt; clear_logs();
    push_word(4'b1010);
    bus.in_valid = 1'b0;
    wait_idle(100);
    chk("t2_ndrive", 32'(drv_j.size()), 32'd1);
    chk("t2_J", 32'(drv_j[0]), 32'b1010);
    chk("t2_K", 32'(drv_k[0]), 32'b0000);
    chk("t2_Q", 32'(bank_q), 32'b1010);
    chk("t2_done", 32'(done_cnt - d0), 32'd1);
    chk("t2_steps", 32'(bus.steps), 32'(s0 + 8'd1));
    chk("t2_err", 32'(bus.err), 32'd0);

    // Back-to-back words.
    s0 = bus.steps; d0 = done_cnt; clear_logs();
    push_word(4'b1010);
    push_word(4'b0110);
    bus.in_valid = 1'b0;
    wait_idle(100);
    chk("t3_ndrive", 32'(drv_j.size()), 32'd2);
    chk("t3_J2", 32'(drv_j[1]), 32'b0100);
    chk("t3_K2", 32'(drv_k[1]), 32'b1000);
    chk("t3_Q", 32'(bank_q), 32'b0110);
    chk("t3_steps", 32'(bus.steps), 32'(s0 + 8'd2));

    // Six words into a slow drain: FIFO fills and backpressures.
    s0 = bus.steps; clear_logs(); saw_block = 0;
    for (int i = 0; i < 6; i++) push_word(words[i]);
    bus.in_valid = 1'b0;
    wait_idle(200);
    chk("t4_backpressure", 32'(saw_block), 32'd1);
    chk("t4_Q", 32'(bank_q), 32'b1100);
    chk("t4_steps", 32'(bus.steps), 32'(s0 + 8'd6));
    chk("t4_napplied", 32'(done_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk("t4_order", 32'(done_q[i]), 32'(words[i]));

    // Readback bit 0 stuck at 0.
    d0 = done_cnt; clear_logs();
    stuck_mask = 4'b0001;
    @(negedge clk);
    push_word(4'b0001);
    bus.in_valid = 1'b0;
    wait_idle(100);
    chk("t5_J", 32'(drv_j[0]), 32'b0001);
    chk("t5_err", 32'(bus.err), 32'd1);
    push_word(4'b0010);
    push_word(4'b0100);
    bus.in_valid = 1'b0;
    wait_idle(100);
    chk("t5_err_sticky", 32'(bus.err), 32'd1);
    chk("t5_done", 32'(done_cnt - d0), 32'd3);
    stuck_mask = 4'b0000;
    @(negedge clk);

    // Reset during DRIVE with two words queued.
    push_word(4'b1000);
    push_word(4'b0001);
    push_word(4'b0011);
    push_word(4'b0111);
    bus.in_valid = 1'b0;
    n = 0;
    while (!(m_phase == 1 && m_q.size() == 2) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_drive", 32'(n < 50), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("t6_J", 32'(bus.J), 32'd0);
    chk("t6_K", 32'(bus.K), 32'd0);
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_steps", 32'(bus.steps), 32'd0);
    chk("t6_err", 32'(bus.err), 32'd0);
    reset = 1'b1;
    d0 = done_cnt; act_cnt = 0;
    repeat (10) @(negedge clk);
    chk("t6_no_drive", 32'(act_cnt), 32'd0);
    chk("t6_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t6_Q", 32'(bank_q), 32'd0);
    chk("t6_steps_after", 32'(bus.steps), 32'd0);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_target = 4'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_idle(600);
    chk("rand_Q", 32'(bus.q_fb), 32'(m_tgt));
    chk("rand_err", 32'(bus.err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
